// File: rtl/serial_pkg.sv
// Shared definitions for the serial IP: state encoding, frame format codes and CONTROL layout.
package serial_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned FIFO_W = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] PAR_EVEN   = 2'b00;
    localparam logic [1:0] PAR_ODD    = 2'b01;
    localparam logic [1:0] PAR_STICK0 = 2'b10;
    localparam logic [1:0] PAR_STICK1 = 2'b11;

    localparam logic [1:0] WLEN_5 = 2'b00;
    localparam logic [1:0] WLEN_6 = 2'b01;
    localparam logic [1:0] WLEN_7 = 2'b10;
    localparam logic [1:0] WLEN_8 = 2'b11;

    localparam int unsigned CONTROL_ENABLE          = 4;
    localparam int unsigned CONTROL_TEST            = 5;
    localparam int unsigned CONTROL_WORD_LEN_LSB    = 6;
    localparam int unsigned CONTROL_PARITY_EN       = 8;
    localparam int unsigned CONTROL_PARITY_MODE_LSB = 9;
    localparam int unsigned CONTROL_TWO_STOP        = 11;

    // Parity bit for the active data bits of a word under the given mode.
    function automatic logic calc_parity(input logic [DATA_W-1:0] data,
                                         input logic [1:0]        wlen,
                                         input logic [1:0]        mode);
        logic [DATA_W-1:0] mask;
        logic              x;
        logic              result;
        case (wlen)
            WLEN_5:  mask = 8'h1F;
            WLEN_6:  mask = 8'h3F;
            WLEN_7:  mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        x = ^(data & mask);
        case (mode)
            PAR_EVEN:   result = x;
            PAR_ODD:    result = ~x;
            PAR_STICK0: result = 1'b0;
            default:    result = 1'b1;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Oversample tick counter; flags the baud tick that closes a bit period.
module serial_bit_timer
    import serial_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic baud_tick,
    output logic bit_end
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);

    logic [CNT_W-1:0] r_cnt;

    // Count ticks modulo OVERSAMPLE; a clear restarts the bit period and drops any tick in that cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (baud_tick) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bit_end = baud_tick && (r_cnt == CNT_W'(OVERSAMPLE - 1));

endmodule

// File: rtl/serial_tx_ctrl.sv
// Transmit sequencer: pops one FIFO word per frame and serialises it as start/data/parity/stop.
module serial_tx_ctrl
    import serial_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                baud_tick,
    input  logic [1:0]          word_len,
    input  logic                parity_en,
    input  logic [1:0]          parity_mode,
    input  logic                two_stop,
    input  logic                fifo_empty,
    input  logic [FIFO_W-1:0]   fifo_rd_data,
    output logic                fifo_rd_request,
    output logic                tx,
    output logic                busy,
    output logic                frame_done
);

    tx_state_t         r_state;
    logic [DATA_W-1:0] r_shift;
    logic [1:0]        r_len;
    logic              r_par_en;
    logic              r_par_bit;
    logic              r_two_stop;
    logic [2:0]        r_bit_cnt;
    logic              r_stop_cnt;
    logic              r_tx;
    logic              r_busy;
    logic              r_rd_req;
    logic              r_frame_done;

    tx_state_t         w_state_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [1:0]        w_len_nxt;
    logic              w_par_en_nxt;
    logic              w_par_bit_nxt;
    logic              w_two_stop_nxt;
    logic [2:0]        w_bit_cnt_nxt;
    logic              w_stop_cnt_nxt;
    logic              w_tx_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_load;
    logic              w_start_ok;
    logic              w_bit_end;
    logic [2:0]        w_last_bit;
    logic              w_unused;

    assign w_start_ok = enable && !fifo_empty;
    assign w_last_bit = {1'b0, r_len} + 3'd4;
    assign w_unused   = &{1'b0, fifo_rd_data[FIFO_W-1]};

    serial_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_load),
        .baud_tick (baud_tick),
        .bit_end   (w_bit_end)
    );

    // Next-state, frame load and next registered output values.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_len_nxt      = r_len;
        w_par_en_nxt   = r_par_en;
        w_par_bit_nxt  = r_par_bit;
        w_two_stop_nxt = r_two_stop;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_load         = 1'b0;
        w_done_nxt     = 1'b0;
        w_tx_nxt       = 1'b1;
        w_busy_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_load = 1'b1;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt   = DATA;
                    w_bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
                    if (r_bit_cnt == w_last_bit) begin
                        w_state_nxt    = r_par_en ? PARITY : STOP;
                        w_stop_cnt_nxt = 1'b0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt    = STOP;
                    w_stop_cnt_nxt = 1'b0;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (r_two_stop && !r_stop_cnt) begin
                        w_stop_cnt_nxt = 1'b1;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                        if (w_start_ok) begin
                            w_load = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Frame format is captured only here, so mid-frame config changes are invisible.
        if (w_load) begin
            w_state_nxt    = START;
            w_shift_nxt    = fifo_rd_data[DATA_W-1:0];
            w_len_nxt      = word_len;
            w_par_en_nxt   = parity_en;
            w_par_bit_nxt  = calc_parity(fifo_rd_data[DATA_W-1:0], word_len, parity_mode);
            w_two_stop_nxt = two_stop;
            w_bit_cnt_nxt  = '0;
            w_stop_cnt_nxt = 1'b0;
        end

        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            PARITY:  w_tx_nxt = w_par_bit_nxt;
            default: w_tx_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // State and frame datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_len      <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_len      <= w_len_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_bit  <= w_par_bit_nxt;
            r_two_stop <= w_two_stop_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
        end
    end

    // Registered outputs; the pop pulse appears the cycle after the load decision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_rd_req     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_tx         <= w_tx_nxt;
            r_busy       <= w_busy_nxt;
            r_rd_req     <= w_load;
            r_frame_done <= w_done_nxt;
        end
    end

    assign tx              = r_tx;
    assign busy            = r_busy;
    assign fifo_rd_request = r_rd_req;
    assign frame_done      = r_frame_done;

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Scoreboard bench for serial_tx_ctrl: expected frames queued at push time, line monitor decodes tx.
module tb_serial_tx_ctrl;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       baud_tick;
    logic [1:0] word_len;
    logic       parity_en;
    logic [1:0] parity_mode;
    logic       two_stop;
    logic       fifo_empty;
    logic [8:0] fifo_rd_data;
    logic       fifo_rd_request;
    logic       tx;
    logic       busy;
    logic       frame_done;

    always #5 clk = ~clk;

    serial_tx_ctrl #(.OVERSAMPLE(OS)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .baud_tick       (baud_tick),
        .word_len        (word_len),
        .parity_en       (parity_en),
        .parity_mode     (parity_mode),
        .two_stop        (two_stop),
        .fifo_empty      (fifo_empty),
        .fifo_rd_data    (fifo_rd_data),
        .fifo_rd_request (fifo_rd_request),
        .tx              (tx),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    typedef struct {
        logic [11:0] bits;
        int          nb;
    } frame_t;

    frame_t     exp_q[$];
    logic [8:0] fifo_q[$];
    logic [8:0] push_q[$];
    frame_t     cur;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int frames_done = 0;
    int req_err = 0;
    int idle_err = 0;
    int fr_err = 0;
    int mon_ticks = 0;
    int tick_period = 1;
    int tick_cnt = 0;
    bit in_frame = 1'b0;
    bit exp_req = 1'b0;
    bit flush = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Line-level frame image from the format rules: start, N data LSB first, parity, stops.
    function automatic frame_t make_frame(input logic [7:0] d, input logic [1:0] wl,
                                          input logic pe, input logic [1:0] pm, input logic ts);
        frame_t f;
        int     n;
        int     ones;
        logic   p;
        n      = int'(wl) + 5;
        f.bits = '1;
        f.bits[0] = 1'b0;
        ones   = 0;
        for (int i = 0; i < n; i++) begin
            f.bits[1 + i] = d[i];
            ones += int'(d[i]);
        end
        f.nb = 1 + n;
        if (pe) begin
            case (pm)
                2'b00:   p = ((ones % 2) == 1);
                2'b01:   p = ((ones % 2) == 0);
                2'b10:   p = 1'b0;
                default: p = 1'b1;
            endcase
            f.bits[f.nb] = p;
            f.nb++;
        end
        f.nb += ts ? 2 : 1;
        return f;
    endfunction

    // Per-cycle monitor, FIFO model and baud tick source, all sampled mid-cycle.
    initial begin
        logic [8:0] popped;
        bit         just_ended;
        forever begin
            @(negedge clk);
            just_ended = 1'b0;
            if (!reset) begin
                in_frame = 1'b0;
            end else begin
                if (fifo_rd_request != exp_req) req_err++;
                if (in_frame && mon_ticks >= cur.nb * OS) begin
                    check("frame_bits", fr_err, 0);
                    check("frame_done_at_end", int'(frame_done), 1);
                    if (frame_done) frames_done++;
                    in_frame   = 1'b0;
                    just_ended = 1'b1;
                end
                if (fifo_rd_request) begin
                    check("pop_has_expected_frame", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        cur       = exp_q.pop_front();
                        in_frame  = 1'b1;
                        mon_ticks = 0;
                        fr_err    = 0;
                    end
                end
                if (in_frame) begin
                    if (tx !== cur.bits[mon_ticks / OS]) fr_err++;
                    if (busy !== 1'b1) fr_err++;
                    if (frame_done && !just_ended) fr_err++;
                end else begin
                    if (tx !== 1'b1 || busy !== 1'b0 || (frame_done && !just_ended)) idle_err++;
                end
            end
            if (fifo_rd_request) begin
                if (fifo_q.size() != 0) popped = fifo_q.pop_front();
                pops++;
            end
            if (flush) begin
                fifo_q.delete();
                flush = 1'b0;
            end
            while (push_q.size() != 0) fifo_q.push_back(push_q.pop_front());
            fifo_empty   = (fifo_q.size() == 0);
            fifo_rd_data = fifo_empty ? 9'h1E7 : fifo_q[0];
            if (tick_period == 0) begin
                baud_tick = 1'($urandom_range(0, 1));
            end else begin
                tick_cnt++;
                if (tick_cnt >= tick_period) begin
                    tick_cnt  = 0;
                    baud_tick = 1'b1;
                end else begin
                    baud_tick = 1'b0;
                end
            end
            if (in_frame && baud_tick) mon_ticks++;
            exp_req = reset && enable && !fifo_empty && (!in_frame || mon_ticks >= cur.nb * OS);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [8:0] w);
        push_q.push_back(w);
        exp_q.push_back(make_frame(w[7:0], word_len, parity_en, parity_mode, two_stop));
    endtask

    task automatic set_cfg(input logic [1:0] wl, input logic pe, input logic [1:0] pm, input logic ts);
        word_len    = wl;
        parity_en   = pe;
        parity_mode = pm;
        two_stop    = ts;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            step();
            if (exp_q.size() == 0 && push_q.size() == 0 && !in_frame) done = 1'b1;
        end
        check({name, " idle_reached"}, int'(done), 1);
        repeat (3) step();
    endtask

    task automatic phase_end(input string name, input int exp_pops, input int exp_frames);
        check({name, " pops"}, pops, exp_pops);
        check({name, " frames"}, frames_done, exp_frames);
        check({name, " request_timing_errs"}, req_err, 0);
        check({name, " idle_line_errs"}, idle_err, 0);
        pops        = 0;
        frames_done = 0;
        req_err     = 0;
        idle_err    = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        bit   hit;
        int   n;
        reset        = 1'b0;
        enable       = 1'b0;
        baud_tick    = 1'b0;
        fifo_empty   = 1'b1;
        fifo_rd_data = '0;
        set_cfg(2'b11, 1'b0, 2'b00, 1'b0);
        repeat (3) step();
        check("reset tx", int'(tx), 1);
        check("reset busy", int'(busy), 0);
        check("reset fifo_rd_request", int'(fifo_rd_request), 0);
        check("reset frame_done", int'(frame_done), 0);
        reset = 1'b1;
        repeat (4) step();
        phase_end("post_reset", 0, 0);

        // single 8N1 frame
        push(9'h055);
        enable = 1'b1;
        wait_idle("8N1", 2000);
        phase_end("8N1", 1, 1);

        // 7 data bits, odd parity, two stops
        set_cfg(2'b10, 1'b1, 2'b01, 1'b1);
        push(9'h041);
        wait_idle("7O2", 2000);
        phase_end("7O2", 1, 1);

        // back-to-back frames
        set_cfg(2'b11, 1'b0, 2'b00, 1'b0);
        push(9'h0A5);
        push(9'h03C);
        wait_idle("b2b", 4000);
        phase_end("b2b", 2, 2);

        // enable dropped during DATA of first frame
        enable = 1'b0;
        step();
        push(9'h111);
        push(9'h022);
        step();
        enable = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            step();
            if (in_frame) hit = 1'b1;
        end
        check("disable frame_started", int'(hit), 1);
        repeat (40) step();
        enable = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            step();
            if (!in_frame) hit = 1'b1;
        end
        check("disable frame_finished", int'(hit), 1);
        repeat (30) step();
        check("disable leftover_frames", exp_q.size(), 1);
        check("disable tx", int'(tx), 1);
        check("disable busy", int'(busy), 0);
        phase_end("disable", 1, 1);
        flush = 1'b1;
        exp_q.delete();
        step();

        // reset during the parity bit
        set_cfg(2'b11, 1'b1, 2'b00, 1'b0);
        enable = 1'b1;
        push(9'($urandom_range(0, 511)));
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            step();
            if (in_frame && mon_ticks >= 9 * OS + 3) hit = 1'b1;
        end
        check("reset_mid parity_reached", int'(hit), 1);
        reset = 1'b0;
        step();
        check("reset_mid tx", int'(tx), 1);
        check("reset_mid busy", int'(busy), 0);
        check("reset_mid fifo_rd_request", int'(fifo_rd_request), 0);
        reset = 1'b1;
        push(9'($urandom_range(0, 511)));
        wait_idle("reset_mid", 2000);
        phase_end("reset_mid", 2, 1);

        // sparse ticks: empty FIFO stays quiet, then one 80-cycle-per-bit frame
        tick_period = 5;
        set_cfg(2'b11, 1'b0, 2'b00, 1'b0);
        repeat (400) step();
        check("empty tx", int'(tx), 1);
        check("empty busy", int'(busy), 0);
        phase_end("empty", 0, 0);
        push(9'($urandom_range(0, 511)));
        wait_idle("sparse", 3000);
        phase_end("sparse", 1, 1);

        // randomized formats, tick patterns and burst sizes
        for (int r = 0; r < 8; r++) begin
            set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            tick_period = $urandom_range(0, 3);
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) push(9'($urandom_range(0, 511)));
            wait_idle("random", 6000);
            phase_end("random", n, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
